// File: rtl/ysyx_23060236_pkg.sv
// Shared types for the ysyx_23060236 AXI arbiter: FSM encoding, grant owner and AXI constants.
package ysyx_23060236_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRdAddr,
        StRdData,
        StWr,
        StWrResp
    } arb_state_e;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_IFU,
        GNT_LSU_RD,
        GNT_LSU_WR
    } grant_e;

    localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
    localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;
    localparam int unsigned AXI_ID_W       = 4;

endpackage

// File: rtl/ysyx_23060236_arb_pick.sv
// Combinational grant select: writes beat reads; read conflicts go to LSU unless the
// round-robin pointer says LSU was served last.
module ysyx_23060236_arb_pick
    import ysyx_23060236_pkg::*;
(
    input  logic       ifu_req,
    input  logic       lsu_rd_req,
    input  logic       lsu_wr_req,
    input  logic       rr_en,
    input  logic       last_lsu,
    output logic [1:0] grant
);

    always_comb begin
        grant = GNT_NONE;
        if (lsu_wr_req) begin
            grant = GNT_LSU_WR;
        end else if (lsu_rd_req && ifu_req) begin
            grant = (rr_en && last_lsu) ? GNT_IFU : GNT_LSU_RD;
        end else if (lsu_rd_req) begin
            grant = GNT_LSU_RD;
        end else if (ifu_req) begin
            grant = GNT_IFU;
        end
    end

endmodule

// File: rtl/ysyx_23060236_arbiter.sv
// Single-outstanding AXI arbiter merging IFU reads and LSU reads/writes onto one master port.
// Define YSYX_23060236_ARB_RR_EN to round-robin IFU/LSU read conflicts.
module ysyx_23060236_arbiter
    import ysyx_23060236_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                clock,
    input  logic                reset,

    input  logic                ifu_arvalid,
    output logic                ifu_arready,
    input  logic [ADDR_W-1:0]   ifu_araddr,
    input  logic [7:0]          ifu_arlen,
    input  logic [2:0]          ifu_arsize,
    output logic                ifu_rvalid,
    input  logic                ifu_rready,
    output logic [DATA_W-1:0]   ifu_rdata,
    output logic [1:0]          ifu_rresp,
    output logic                ifu_rlast,

    input  logic                lsu_arvalid,
    output logic                lsu_arready,
    input  logic [ADDR_W-1:0]   lsu_araddr,
    input  logic [7:0]          lsu_arlen,
    input  logic [2:0]          lsu_arsize,
    output logic                lsu_rvalid,
    input  logic                lsu_rready,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic [1:0]          lsu_rresp,
    output logic                lsu_rlast,

    input  logic                lsu_awvalid,
    output logic                lsu_awready,
    input  logic [ADDR_W-1:0]   lsu_awaddr,
    input  logic [2:0]          lsu_awsize,
    input  logic                lsu_wvalid,
    output logic                lsu_wready,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [3:0]          lsu_wstrb,
    output logic                lsu_bvalid,
    input  logic                lsu_bready,
    output logic [1:0]          lsu_bresp,

    output logic                io_master_arvalid,
    input  logic                io_master_arready,
    output logic [ADDR_W-1:0]   io_master_araddr,
    output logic [7:0]          io_master_arlen,
    output logic [2:0]          io_master_arsize,
    output logic [1:0]          io_master_arburst,
    output logic [AXI_ID_W-1:0] io_master_arid,
    input  logic                io_master_rvalid,
    output logic                io_master_rready,
    input  logic [DATA_W-1:0]   io_master_rdata,
    input  logic [1:0]          io_master_rresp,
    input  logic                io_master_rlast,

    output logic                io_master_awvalid,
    input  logic                io_master_awready,
    output logic [ADDR_W-1:0]   io_master_awaddr,
    output logic [7:0]          io_master_awlen,
    output logic [2:0]          io_master_awsize,
    output logic [1:0]          io_master_awburst,
    output logic [AXI_ID_W-1:0] io_master_awid,
    output logic                io_master_wvalid,
    input  logic                io_master_wready,
    output logic [DATA_W-1:0]   io_master_wdata,
    output logic [3:0]          io_master_wstrb,
    output logic                io_master_wlast,
    input  logic                io_master_bvalid,
    output logic                io_master_bready,
    input  logic [1:0]          io_master_bresp,

    output logic                proto_err
);

    arb_state_e state_q, state_d;
    grant_e     grant_q, grant_d;
    grant_e     pick;
    logic [1:0] pick_grant;
    logic [7:0] beat_cnt_q, beat_cnt_d;
    logic       aw_done_q, aw_done_d;
    logic       w_done_q, w_done_d;
    logic       proto_err_q, proto_err_d;
    logic       rr_en, last_lsu;

    ysyx_23060236_arb_pick u_pick (
        .ifu_req    (ifu_arvalid),
        .lsu_rd_req (lsu_arvalid),
        .lsu_wr_req (lsu_awvalid),
        .rr_en      (rr_en),
        .last_lsu   (last_lsu),
        .grant      (pick_grant)
    );

    assign pick = grant_e'(pick_grant);

`ifdef YSYX_23060236_ARB_RR_EN
    // 1 = LSU won the most recent read grant; reset to IFU so LSU wins the first conflict.
    logic last_grant_q, last_grant_d;

    assign rr_en    = 1'b1;
    assign last_lsu = last_grant_q;

    always_comb begin
        last_grant_d = last_grant_q;
        if (state_q == StIdle && pick == GNT_LSU_RD) begin
            last_grant_d = 1'b1;
        end else if (state_q == StIdle && pick == GNT_IFU) begin
            last_grant_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_grant_q <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`else
    assign rr_en    = 1'b0;
    assign last_lsu = 1'b0;
`endif

    logic in_rd_addr, in_rd_data, in_wr, in_wr_resp;
    logic sel_ifu, sel_lsu;
    logic req_arvalid, req_rready;
    logic ar_hs, r_hs, aw_hs, w_hs, b_hs;

    assign in_rd_addr  = (state_q == StRdAddr);
    assign in_rd_data  = (state_q == StRdData);
    assign in_wr       = (state_q == StWr);
    assign in_wr_resp  = (state_q == StWrResp);
    assign sel_ifu     = (grant_q == GNT_IFU);
    assign sel_lsu     = (grant_q == GNT_LSU_RD);
    assign req_arvalid = sel_lsu ? lsu_arvalid : ifu_arvalid;
    assign req_rready  = sel_lsu ? lsu_rready  : ifu_rready;

    // Read address channel
    assign io_master_arvalid = in_rd_addr && req_arvalid;
    assign io_master_araddr  = sel_lsu ? lsu_araddr : ifu_araddr;
    assign io_master_arlen   = sel_lsu ? lsu_arlen  : ifu_arlen;
    assign io_master_arsize  = sel_lsu ? lsu_arsize : ifu_arsize;
    assign io_master_arburst = AXI_BURST_INCR;
    assign io_master_arid    = '0;
    assign ifu_arready       = in_rd_addr && sel_ifu && io_master_arready;
    assign lsu_arready       = in_rd_addr && sel_lsu && io_master_arready;

    // Read data channel; payload fans out, only the valid is steered
    assign io_master_rready = in_rd_data && req_rready;
    assign ifu_rvalid       = in_rd_data && sel_ifu && io_master_rvalid;
    assign lsu_rvalid       = in_rd_data && sel_lsu && io_master_rvalid;
    assign ifu_rdata        = io_master_rdata;
    assign ifu_rresp        = io_master_rresp;
    assign ifu_rlast        = io_master_rlast;
    assign lsu_rdata        = io_master_rdata;
    assign lsu_rresp        = io_master_rresp;
    assign lsu_rlast        = io_master_rlast;

    // Write channels: aw and w each complete once, in either order
    assign io_master_awvalid = in_wr && !aw_done_q && lsu_awvalid;
    assign lsu_awready       = in_wr && !aw_done_q && io_master_awready;
    assign io_master_awaddr  = lsu_awaddr;
    assign io_master_awlen   = 8'd0;
    assign io_master_awsize  = lsu_awsize;
    assign io_master_awburst = AXI_BURST_INCR;
    assign io_master_awid    = '0;
    assign io_master_wvalid  = in_wr && !w_done_q && lsu_wvalid;
    assign lsu_wready        = in_wr && !w_done_q && io_master_wready;
    assign io_master_wdata   = lsu_wdata;
    assign io_master_wstrb   = lsu_wstrb;
    assign io_master_wlast   = 1'b1;
    assign lsu_bvalid        = in_wr_resp && io_master_bvalid;
    assign io_master_bready  = in_wr_resp && lsu_bready;
    assign lsu_bresp         = io_master_bresp;

    assign ar_hs = io_master_arvalid && io_master_arready;
    assign r_hs  = io_master_rvalid  && io_master_rready;
    assign aw_hs = io_master_awvalid && io_master_awready;
    assign w_hs  = io_master_wvalid  && io_master_wready;
    assign b_hs  = io_master_bvalid  && io_master_bready;

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        beat_cnt_d  = beat_cnt_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        proto_err_d = proto_err_q;
        unique case (state_q)
            StIdle: begin
                if (pick != GNT_NONE) begin
                    grant_d = pick;
                    state_d = (pick == GNT_LSU_WR) ? StWr : StRdAddr;
                end
            end
            StRdAddr: begin
                if (ar_hs) begin
                    beat_cnt_d = io_master_arlen;
                    state_d    = StRdData;
                end
            end
            StRdData: begin
                if (r_hs) begin
                    // rlast always ends the burst; a count mismatch is only flagged.
                    if (io_master_rlast) begin
                        if (beat_cnt_q != 8'd0) begin
                            proto_err_d = 1'b1;
                        end
                        beat_cnt_d = 8'd0;
                        grant_d    = GNT_NONE;
                        state_d    = StIdle;
                    end else if (beat_cnt_q == 8'd0) begin
                        proto_err_d = 1'b1;
                    end else begin
                        beat_cnt_d = beat_cnt_q - 8'd1;
                    end
                end
            end
            StWr: begin
                aw_done_d = aw_done_q | aw_hs;
                w_done_d  = w_done_q | w_hs;
                if (aw_done_d && w_done_d) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = StWrResp;
                end
            end
            StWrResp: begin
                if (b_hs) begin
                    grant_d = GNT_NONE;
                    state_d = StIdle;
                end
            end
            default: begin
                grant_d = GNT_NONE;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            grant_q     <= GNT_NONE;
            beat_cnt_q  <= 8'd0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            beat_cnt_q  <= beat_cnt_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign proto_err = proto_err_q;

endmodule

// File: tb/tb_ysyx_23060236_arbiter.sv
// Self-checking bench for ysyx_23060236_arbiter: table of read transactions plus
// hand-written reset, early-rlast and write sequences; read beats go through a scoreboard.
module tb_ysyx_23060236_arbiter;
    import ysyx_23060236_pkg::*;

    logic                clock, reset;
    logic                ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rready, ifu_rlast;
    logic [31:0]         ifu_araddr, ifu_rdata;
    logic [7:0]          ifu_arlen;
    logic [2:0]          ifu_arsize;
    logic [1:0]          ifu_rresp;
    logic                lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rready, lsu_rlast;
    logic [31:0]         lsu_araddr, lsu_rdata;
    logic [7:0]          lsu_arlen;
    logic [2:0]          lsu_arsize;
    logic [1:0]          lsu_rresp;
    logic                lsu_awvalid, lsu_awready, lsu_wvalid, lsu_wready, lsu_bvalid, lsu_bready;
    logic [31:0]         lsu_awaddr, lsu_wdata;
    logic [2:0]          lsu_awsize;
    logic [3:0]          lsu_wstrb;
    logic [1:0]          lsu_bresp;
    logic                m_arvalid, m_arready, m_rvalid, m_rready, m_rlast;
    logic [31:0]         m_araddr, m_rdata;
    logic [7:0]          m_arlen, m_awlen;
    logic [2:0]          m_arsize, m_awsize;
    logic [1:0]          m_arburst, m_rresp, m_awburst, m_bresp;
    logic [AXI_ID_W-1:0] m_arid, m_awid;
    logic                m_awvalid, m_awready, m_wvalid, m_wready, m_wlast, m_bvalid, m_bready;
    logic [31:0]         m_awaddr, m_wdata;
    logic [3:0]          m_wstrb;
    logic                proto_err;

    ysyx_23060236_arbiter dut (
        .clock (clock), .reset (reset),
        .ifu_arvalid (ifu_arvalid), .ifu_arready (ifu_arready), .ifu_araddr (ifu_araddr),
        .ifu_arlen (ifu_arlen), .ifu_arsize (ifu_arsize), .ifu_rvalid (ifu_rvalid),
        .ifu_rready (ifu_rready), .ifu_rdata (ifu_rdata), .ifu_rresp (ifu_rresp),
        .ifu_rlast (ifu_rlast),
        .lsu_arvalid (lsu_arvalid), .lsu_arready (lsu_arready), .lsu_araddr (lsu_araddr),
        .lsu_arlen (lsu_arlen), .lsu_arsize (lsu_arsize), .lsu_rvalid (lsu_rvalid),
        .lsu_rready (lsu_rready), .lsu_rdata (lsu_rdata), .lsu_rresp (lsu_rresp),
        .lsu_rlast (lsu_rlast),
        .lsu_awvalid (lsu_awvalid), .lsu_awready (lsu_awready), .lsu_awaddr (lsu_awaddr),
        .lsu_awsize (lsu_awsize), .lsu_wvalid (lsu_wvalid), .lsu_wready (lsu_wready),
        .lsu_wdata (lsu_wdata), .lsu_wstrb (lsu_wstrb), .lsu_bvalid (lsu_bvalid),
        .lsu_bready (lsu_bready), .lsu_bresp (lsu_bresp),
        .io_master_arvalid (m_arvalid), .io_master_arready (m_arready),
        .io_master_araddr (m_araddr), .io_master_arlen (m_arlen), .io_master_arsize (m_arsize),
        .io_master_arburst (m_arburst), .io_master_arid (m_arid),
        .io_master_rvalid (m_rvalid), .io_master_rready (m_rready), .io_master_rdata (m_rdata),
        .io_master_rresp (m_rresp), .io_master_rlast (m_rlast),
        .io_master_awvalid (m_awvalid), .io_master_awready (m_awready),
        .io_master_awaddr (m_awaddr), .io_master_awlen (m_awlen), .io_master_awsize (m_awsize),
        .io_master_awburst (m_awburst), .io_master_awid (m_awid),
        .io_master_wvalid (m_wvalid), .io_master_wready (m_wready), .io_master_wdata (m_wdata),
        .io_master_wstrb (m_wstrb), .io_master_wlast (m_wlast),
        .io_master_bvalid (m_bvalid), .io_master_bready (m_bready), .io_master_bresp (m_bresp),
        .proto_err (proto_err)
    );

    typedef struct {
        logic        ifu_req;
        logic        lsu_req;
        logic [31:0] ifu_addr;
        logic [31:0] lsu_addr;
        logic [7:0]  len;
        int          last_at;
        logic        exp_lsu;
        logic        exp_err;
    } rd_vec_t;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } beat_t;

    beat_t   sb[$];
    rd_vec_t vecs[6];
    rd_vec_t v;
    int      n_vec = 0;
    int      n_err = 0;
    int      aw_cnt = 0;
    int      w_cnt = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Handshakes are sampled mid-cycle where valid/ready are stable up to the next edge.
    always @(negedge clock) begin
        if (m_awvalid && m_awready) aw_cnt++;
        if (m_wvalid && m_wready) w_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required self-termination");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] bdata(input logic [31:0] a, input int i);
        return (a + 32'(i * 4)) ^ 32'hA5A5_0000;
    endfunction

    // Called inside an IDLE cycle; leaves the winner's address accepted and the FSM in RD_DATA.
    task automatic rd_start(input rd_vec_t e);
        logic [31:0] exp_addr;
        exp_addr    = e.exp_lsu ? e.lsu_addr : e.ifu_addr;
        ifu_arvalid = e.ifu_req;
        ifu_araddr  = e.ifu_addr;
        ifu_arlen   = e.len;
        ifu_arsize  = 3'd2;
        lsu_arvalid = e.lsu_req;
        lsu_araddr  = e.lsu_addr;
        lsu_arlen   = e.len;
        lsu_arsize  = 3'd2;
        m_arready   = 1'b0;
        #1;
        chk("idle_arvalid", m_arvalid, 0);
        tick();
        @(negedge clock);
        chk("arvalid_latency", m_arvalid, 1);
        chk("araddr", m_araddr, exp_addr);
        chk("arlen", m_arlen, e.len);
        chk("arburst", m_arburst, AXI_BURST_INCR);
        tick();
        m_arready = 1'b1;
        @(negedge clock);
        chk("win_arready", e.exp_lsu ? lsu_arready : ifu_arready, 1);
        chk("lose_arready", e.exp_lsu ? ifu_arready : lsu_arready, 0);
        tick();
        m_arready = 1'b0;
        if (e.exp_lsu) lsu_arvalid = 1'b0;
        else ifu_arvalid = 1'b0;
    endtask

    task automatic rd_beat(input logic to_lsu, input logic [31:0] data, input logic last);
        beat_t e;
        m_rvalid   = 1'b1;
        m_rdata    = data;
        m_rlast    = last;
        m_rresp    = AXI_RESP_OKAY;
        ifu_rready = !to_lsu;
        lsu_rready = to_lsu;
        sb.push_back('{data: data, last: last});
        @(negedge clock);
        e = sb.pop_front();
        chk("r_route", to_lsu ? lsu_rvalid : ifu_rvalid, 1);
        chk("r_other", to_lsu ? ifu_rvalid : lsu_rvalid, 0);
        chk("rdata", to_lsu ? lsu_rdata : ifu_rdata, e.data);
        chk("rlast", to_lsu ? lsu_rlast : ifu_rlast, e.last);
        chk("m_rready", m_rready, 1);
        tick();
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
    endtask

    task automatic do_read(input rd_vec_t e);
        logic [31:0] a;
        a = e.exp_lsu ? e.lsu_addr : e.ifu_addr;
        rd_start(e);
        for (int i = 0; i <= e.last_at; i++) begin
            rd_beat(e.exp_lsu, bdata(a, i), i == e.last_at);
        end
        #1;
        chk("idle_rready", m_rready, 0);
        chk("idle_arvalid_after", m_arvalid, 0);
        chk("proto_err", proto_err, e.exp_err);
    endtask

    initial begin
        reset = 1'b0;
        {ifu_arvalid, ifu_rready, lsu_arvalid, lsu_rready} = '0;
        {lsu_awvalid, lsu_wvalid, lsu_bready} = '0;
        {m_arready, m_rvalid, m_rlast, m_awready, m_wready, m_bvalid} = '0;
        ifu_araddr = '0; ifu_arlen = '0; ifu_arsize = '0;
        lsu_araddr = '0; lsu_arlen = '0; lsu_arsize = '0;
        lsu_awaddr = '0; lsu_awsize = '0; lsu_wdata = '0; lsu_wstrb = '0;
        m_rdata = '0; m_rresp = '0; m_bresp = '0;

        vecs[0] = '{1'b1, 1'b0, 32'h8000_0000, 32'h0, 8'd3, 3, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 32'h8000_1000, 32'h8000_2000, 8'd1, 1, 1'b1, 1'b0};
`ifdef YSYX_23060236_ARB_RR_EN
        vecs[2] = '{1'b1, 1'b1, 32'h8000_1000, 32'h8000_3000, 8'd1, 1, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 32'h0, 32'h8000_3000, 8'd1, 1, 1'b1, 1'b0};
`else
        vecs[2] = '{1'b1, 1'b1, 32'h8000_1000, 32'h8000_3000, 8'd1, 1, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 32'h8000_1000, 32'h0, 8'd1, 1, 1'b0, 1'b0};
`endif
        vecs[4] = '{1'b0, 1'b1, 32'h0, 32'h8000_4000, 8'd2, 2, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 32'h8000_5000, 32'h0, 8'd0, 1, 1'b0, 1'b1};

        #2;
        chk("rst_arvalid", m_arvalid, 0);
        chk("rst_awvalid", m_awvalid, 0);
        chk("rst_ifu_arready", ifu_arready, 0);
        chk("rst_bvalid", lsu_bvalid, 0);
        chk("rst_proto_err", proto_err, 0);
        #10 reset = 1'b1;
        tick();

        foreach (vecs[k]) do_read(vecs[k]);

        // Asynchronous reset in the middle of a burst
        v = '{1'b1, 1'b0, 32'h8000_6000, 32'h0, 8'd3, 3, 1'b0, 1'b1};
        rd_start(v);
        rd_beat(1'b0, bdata(v.ifu_addr, 0), 1'b0);
        rd_beat(1'b0, bdata(v.ifu_addr, 1), 1'b0);
        m_rvalid   = 1'b1;
        m_rdata    = bdata(v.ifu_addr, 2);
        ifu_rready = 1'b1;
        @(negedge clock);
        chk("pre_rst_rvalid", ifu_rvalid, 1);
        #1 reset = 1'b0;
        #1;
        chk("mid_rst_rvalid", ifu_rvalid, 0);
        chk("mid_rst_rready", m_rready, 0);
        chk("mid_rst_proto_err", proto_err, 0);
        chk("mid_rst_arvalid", m_arvalid, 0);
        m_rvalid = 1'b0;
        ifu_rready = 1'b0;
        repeat (2) @(posedge clock);
        #3 reset = 1'b1;
        tick();
        chk("post_rst_idle", m_arvalid, 0);
        do_read('{1'b1, 1'b0, 32'h8000_7000, 32'h0, 8'd3, 3, 1'b0, 1'b0});

        // rlast arrives on the third of four expected beats
        do_read('{1'b1, 1'b0, 32'h8000_8000, 32'h0, 8'd3, 2, 1'b0, 1'b1});

        // LSU write with w leading aw by two cycles; IFU requests alongside aw
        tick();
        lsu_wvalid = 1'b1;
        lsu_wdata  = 32'hDEAD_BEEF;
        lsu_wstrb  = 4'hF;
        repeat (2) begin
            @(negedge clock);
            chk("w_early_wvalid", m_wvalid, 0);
            chk("w_early_wready", lsu_wready, 0);
            tick();
        end
        lsu_awvalid = 1'b1;
        lsu_awaddr  = 32'h8000_0100;
        lsu_awsize  = 3'd2;
        ifu_arvalid = 1'b1;
        ifu_araddr  = 32'h8000_9000;
        ifu_arlen   = 8'd1;
        #1 chk("aw_idle", m_awvalid, 0);
        tick();
        m_wready = 1'b1;
        @(negedge clock);
        chk("awvalid", m_awvalid, 1);
        chk("awaddr", m_awaddr, 32'h8000_0100);
        chk("awlen", m_awlen, 0);
        chk("wvalid", m_wvalid, 1);
        chk("wdata", m_wdata, 32'hDEAD_BEEF);
        chk("wstrb", m_wstrb, 4'hF);
        chk("wlast", m_wlast, 1);
        chk("lsu_wready", lsu_wready, 1);
        chk("lsu_awready_wait", lsu_awready, 0);
        chk("wr_ifu_held", m_arvalid, 0);
        tick();
        lsu_wvalid = 1'b0;
        m_wready   = 1'b0;
        m_awready  = 1'b1;
        @(negedge clock);
        chk("w_done_wvalid", m_wvalid, 0);
        chk("awvalid_late", m_awvalid, 1);
        chk("lsu_awready", lsu_awready, 1);
        tick();
        lsu_awvalid = 1'b0;
        m_awready   = 1'b0;
        m_bvalid    = 1'b1;
        m_bresp     = 2'b01;
        lsu_bready  = 1'b1;
        @(negedge clock);
        chk("lsu_bvalid", lsu_bvalid, 1);
        chk("lsu_bresp", lsu_bresp, 2'b01);
        chk("m_bready", m_bready, 1);
        chk("resp_awvalid", m_awvalid, 0);
        chk("resp_ifu_arready", ifu_arready, 0);
        chk("resp_arvalid", m_arvalid, 0);
        chk("aw_count", aw_cnt, 1);
        chk("w_count", w_cnt, 1);
        tick();
        m_bvalid   = 1'b0;
        lsu_bready = 1'b0;
        #1 chk("post_b_bvalid", lsu_bvalid, 0);
        do_read('{1'b1, 1'b0, 32'h8000_9000, 32'h0, 8'd1, 1, 1'b0, 1'b1});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
